// File: rtl/ram_req_ctrl_pkg.sv
// ram_req_ctrl_pkg: shared state encoding and default RAM geometry for the request sequencer.
package ram_req_ctrl_pkg;
    localparam int RAM_AW = 3;
    localparam int RAM_DW = 4;
    localparam int RAM_CW = 8;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_e;
endpackage

// File: rtl/ram_req_ctrl_sat_counter.sv
// sat_counter: CW-bit incrementer that sticks at all-ones, cleared by async active-low reset.
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [CW-1:0] cnt
);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign cnt = cnt_q;
endmodule

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: turns valid/ready load/store requests into block-RAM port cycles,
// hides the RAM's registered-address read latency and returns read data on a response channel.
module ram_req_ctrl
    import ram_req_ctrl_pkg::*;
#(
    parameter int AW = RAM_AW,
    parameter int DW = RAM_DW,
    parameter int CW = RAM_CW
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata,
    output logic [CW-1:0] rd_cnt,
    output logic [CW-1:0] wr_cnt
);
    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          resp_valid_q, resp_valid_d;
    logic [DW-1:0] resp_rdata_q, resp_rdata_d;
    logic          idle, rd_acc, wr_acc;

    assign idle   = state_q == IDLE;
    assign rd_acc = req_valid & idle & ~req_we;
    assign wr_acc = req_valid & idle & req_we;

    assign req_ready  = idle;
    assign ram_we     = wr_acc;
    assign ram_wdata  = req_wdata;
    // Hold the read address on the RAM port while its registered address settles.
    assign ram_addr   = idle ? req_addr : addr_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            IDLE: begin
                if (rd_acc) begin
                    state_d = RD_WAIT;
                    addr_d  = req_addr;
                end
            end
            RD_WAIT: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = ram_rdata;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    sat_counter #(.CW(CW)) u_rd_cnt (.clk(CLK), .rst_n(RST_N), .inc(rd_acc), .cnt(rd_cnt));
    sat_counter #(.CW(CW)) u_wr_cnt (.clk(CLK), .rst_n(RST_N), .inc(wr_acc), .cnt(wr_cnt));
endmodule

// File: tb/tb_ram_req_ctrl.sv
// tb_ram_req_ctrl: random load/store traffic against a behavioural memory/counter model,
// read responses scored from a queue by an independent monitor.
module tb_ram_req_ctrl;
    logic       CLK = 1'b0;
    logic       RST_N;
    logic       req_valid, req_we;
    logic [2:0] req_addr;
    logic [3:0] req_wdata;
    logic       resp_ready;
    logic       req_ready, resp_valid, ram_we;
    logic [3:0] resp_rdata, ram_wdata, ram_rdata;
    logic [2:0] ram_addr;
    logic [7:0] rd_cnt, wr_cnt;
    logic       s_req_ready, s_resp_valid, s_ram_we;
    logic [3:0] s_resp_rdata, s_ram_wdata;
    logic [2:0] s_ram_addr;
    logic [1:0] s_rd_cnt, s_wr_cnt;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    ram_req_ctrl dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    // Narrow-counter twin fed the same traffic, used to observe saturation at 3.
    ram_req_ctrl #(.CW(2)) dut_s (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(s_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(s_resp_valid), .resp_ready(resp_ready), .resp_rdata(s_resp_rdata),
        .ram_addr(s_ram_addr), .ram_wdata(s_ram_wdata), .ram_we(s_ram_we), .ram_rdata(ram_rdata),
        .rd_cnt(s_rd_cnt), .wr_cnt(s_wr_cnt)
    );

    // 8x4 block RAM with registered read address.
    logic [3:0] mem [8];
    logic [2:0] ram_areg;
    always @(posedge CLK) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_areg <= ram_addr;
    end
    assign ram_rdata = mem[ram_areg];

    logic rr_rand = 1'b0;
    logic rr_fixed = 1'b1;
    logic rr_bit = 1'b1;
    assign resp_ready = rr_rand ? rr_bit : rr_fixed;
    initial forever begin
        @(posedge CLK);
        #1 rr_bit = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [3:0] ref_mem [8];
    logic [3:0] sb [$];
    logic       outstanding = 1'b0;
    logic [2:0] out_addr = '0;
    int         cyc = 0, acc_cyc = 0;
    logic       prev_valid = 1'b0, held = 1'b0;
    logic [3:0] held_data = '0;
    int         exp_rd = 0, exp_wr = 0, exp_rd_s = 0, exp_wr_s = 0;

    always @(negedge CLK) begin
        if (!RST_N) begin
            sb.delete();
            outstanding = 1'b0;
            prev_valid  = 1'b0;
            held        = 1'b0;
            exp_rd = 0; exp_wr = 0; exp_rd_s = 0; exp_wr_s = 0;
        end else begin
            logic acc;
            cyc++;
            acc = req_valid && !outstanding;
            chk("req_ready", 32'(req_ready), 32'(!outstanding));
            chk("ram_we", 32'(ram_we), 32'(acc && req_we));
            if (outstanding) chk("ram_addr_hold", 32'(ram_addr), 32'(out_addr));
            else if (req_valid) begin
                chk("ram_addr_pass", 32'(ram_addr), 32'(req_addr));
                chk("ram_wdata_pass", 32'(ram_wdata), 32'(req_wdata));
            end
            if (!outstanding) chk("resp_valid_idle", 32'(resp_valid), 0);
            chk("rd_cnt", 32'(rd_cnt), exp_rd);
            chk("wr_cnt", 32'(wr_cnt), exp_wr);
            chk("rd_cnt_sat2", 32'(s_rd_cnt), exp_rd_s);
            chk("wr_cnt_sat2", 32'(s_wr_cnt), exp_wr_s);
            if (resp_valid && !prev_valid) chk("read_latency", cyc - acc_cyc, 2);
            if (held) begin
                chk("hold_valid", 32'(resp_valid), 1);
                chk("hold_rdata", 32'(resp_rdata), 32'(held_data));
            end
            held = 1'b0;
            if (resp_valid) begin
                if (resp_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL resp_unexpected: got rdata %0h expected no response at %0t", resp_rdata, $time);
                    end else chk("resp_rdata", 32'(resp_rdata), 32'(sb.pop_front()));
                    outstanding = 1'b0;
                end else begin
                    held      = 1'b1;
                    held_data = resp_rdata;
                end
            end
            prev_valid = resp_valid;
            if (acc) begin
                if (req_we) begin
                    ref_mem[req_addr] = req_wdata;
                    exp_wr   = exp_wr < 255 ? exp_wr + 1 : 255;
                    exp_wr_s = exp_wr_s < 3 ? exp_wr_s + 1 : 3;
                end else begin
                    sb.push_back(ref_mem[req_addr]);
                    outstanding = 1'b1;
                    out_addr    = req_addr;
                    acc_cyc     = cyc;
                    exp_rd   = exp_rd < 255 ? exp_rd + 1 : 255;
                    exp_rd_s = exp_rd_s < 3 ? exp_rd_s + 1 : 3;
                end
            end
        end
    end

    task automatic do_req(input logic we, input logic [2:0] a, input logic [3:0] d);
        bit ok;
        int n;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        n = 0;
        do begin
            @(negedge CLK);
            ok = req_ready;
            @(posedge CLK);
            #1 n++;
        end while (!ok && n < 60);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL req_timeout: req_ready stayed 0 for %0d cycles, expected 1", n);
        end
    endtask

    task automatic idle_cycles(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            req_we = 1'($urandom_range(0, 1));
            req_addr = 3'($urandom_range(0, 7));
            req_wdata = 4'($urandom_range(0, 15));
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        RST_N = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_rdata", 32'(resp_rdata), 0);
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_rd_cnt", 32'(rd_cnt), 0);
        chk("rst_wr_cnt", 32'(wr_cnt), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        RST_N = 1'b1;
        idle_cycles(1);
        // write then read, back-to-back read-after-write
        do_req(1'b1, 3'd3, 4'hA);
        do_req(1'b0, 3'd3, 4'h0);
        idle_cycles(3);
        chk("wr_cnt_after_wr_rd", 32'(wr_cnt), 1);
        chk("rd_cnt_after_wr_rd", 32'(rd_cnt), 1);
        do_req(1'b1, 3'd6, 4'h9);
        do_req(1'b0, 3'd6, 4'h0);
        idle_cycles(3);
        // back-pressure with a store held pending while busy
        do_req(1'b1, 3'd5, 4'h6);
        rr_fixed = 1'b0;
        do_req(1'b0, 3'd5, 4'h0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd5; req_wdata = 4'hF;
        repeat (4) begin
            @(posedge CLK);
            #1;
        end
        chk("bp_resp_valid", 32'(resp_valid), 1);
        chk("bp_resp_rdata", 32'(resp_rdata), 4'h6);
        chk("bp_req_ready", 32'(req_ready), 0);
        req_valid = 1'b0;
        rr_fixed = 1'b1;
        @(posedge CLK);
        #1;
        chk("bp_back_idle", 32'(req_ready), 1);
        chk("bp_valid_drop", 32'(resp_valid), 0);
        // burst writes then read back
        for (int i = 0; i < 8; i++) do_req(1'b1, 3'(i), 4'(7 - i));
        chk("burst_wr_cnt", 32'(wr_cnt), 11);
        for (int i = 0; i < 8; i++) do_req(1'b0, 3'(i), 4'h0);
        idle_cycles(3);
        // random mix with random response back-pressure
        rr_rand = 1'b1;
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) idle_cycles(1);
            else do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
        end
        rr_rand = 1'b0;
        idle_cycles(4);
        // reset during a read in flight
        do_req(1'b0, 3'd2, 4'h0);
        req_valid = 1'b0;
        RST_N = 1'b0;
        #2;
        chk("midrst_resp_valid", 32'(resp_valid), 0);
        chk("midrst_req_ready", 32'(req_ready), 1);
        chk("midrst_rd_cnt", 32'(rd_cnt), 0);
        chk("midrst_wr_cnt", 32'(wr_cnt), 0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        idle_cycles(3);
        chk("midrst_no_resp", 32'(resp_valid), 0);
        do_req(1'b0, 3'd2, 4'h0);
        idle_cycles(3);
        // wide counter saturation
        for (int i = 0; i < 260; i++) do_req(1'b1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
        idle_cycles(2);
        chk("wr_cnt_sat", 32'(wr_cnt), 255);
        chk("wr_cnt_sat2_final", 32'(s_wr_cnt), 3);
        for (int i = 0; i < 8; i++) do_req(1'b0, 3'(i), 4'h0);
        idle_cycles(5);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
